demux2: RTL and testbench

Clocked 1-to-2 demultiplexer: the receive end of the 2:1 `mux2` path. Takes a single time-multiplexed data stream and steers each valid word into one of two per-channel one-entry output buffers with valid/ready handshakes. The channel is taken from an external `sel` or from an internal slot counter that mirrors the mux's alternating select. Overflow of a full channel buffer is flagged sticky rather than silently lost.

---
 rtl/demux_pkg.sv | 16 +
 rtl/demux_slot.sv | 42 ++++
 rtl/demux2.sv | 72 +++++++
 tb/tb_demux2.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and helpers for the demux2 receive path.
package demux_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic {
      CH0 = 1'b0,
      CH1 = 1'b1
   } ch_e;

   // Slot counter width; PERIOD=1 still needs a 1-bit register.
   function automatic int cnt_width(input int period);
      return (period <= 1) ? 1 : $clog2(period);
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry per-channel output buffer with valid/ready drain and sticky overrun flag.
module demux_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun
);

   logic drain;
   logic accept;

   assign drain  = out_valid && out_ready;
   assign accept = load && (!out_valid || out_ready);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
         end else if (drain) begin
            out_valid <= 1'b0;
         end
         if (load && !accept) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux2.sv
// Clocked 1-to-2 demultiplexer: slot counter and channel decode feeding two slot buffers.
module demux2
   import demux_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int PERIOD = 5,
   parameter bit AUTO   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             sel,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic             phase,
   output logic             overrun0,
   output logic             overrun1
);

   localparam int             CW       = cnt_width(PERIOD);
   localparam logic [CW-1:0]  CNT_LAST = CW'(PERIOD - 1);

   logic [CW-1:0] cnt;
   ch_e           ch;
   logic          load0;
   logic          load1;

   // Free-running slot counter mirroring the mux's alternating select.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt == CNT_LAST) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign ch    = ch_e'(AUTO ? phase : sel);
   assign load0 = in_valid && (ch == CH0);
   assign load1 = in_valid && (ch == CH1);

   demux_slot #(.WIDTH(WIDTH)) u_slot0 (
      .clk       (clk),
      .rst       (rst),
      .load      (load0),
      .in_data   (in_data),
      .out_data  (out0_data),
      .out_valid (out0_valid),
      .out_ready (out0_ready),
      .overrun   (overrun0)
   );

   demux_slot #(.WIDTH(WIDTH)) u_slot1 (
      .clk       (clk),
      .rst       (rst),
      .load      (load1),
      .in_data   (in_data),
      .out_data  (out1_data),
      .out_valid (out1_valid),
      .out_ready (out1_ready),
      .overrun   (overrun1)
   );

endmodule

// File: tb/tb_demux2.sv
// Bench for demux2: three instances (manual, auto PERIOD=5, auto PERIOD=1) against a behavioural model.
module tb_demux2;

   localparam int NI = 3;
   localparam int PER [NI]  = '{5, 5, 1};
   localparam bit AUT [NI]  = '{1'b0, 1'b1, 1'b1};

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] in_data;
   logic       in_valid;
   logic       sel;
   logic       rdy0;
   logic       rdy1;

   logic [3:0] o0d [NI];
   logic [3:0] o1d [NI];
   logic       o0v [NI];
   logic       o1v [NI];
   logic       ph  [NI];
   logic       ov0 [NI];
   logic       ov1 [NI];

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   // Behavioural model: per-instance, per-channel buffer plus cycles since reset.
   logic [3:0] m_d [NI][2];
   bit         m_v [NI][2];
   bit         m_o [NI][2];
   int         m_n [NI];

   always #5 clk = ~clk;

   demux2 #(.WIDTH(4), .PERIOD(5), .AUTO(1'b0)) dut_m (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .sel(sel),
      .out0_data(o0d[0]), .out0_valid(o0v[0]), .out0_ready(rdy0),
      .out1_data(o1d[0]), .out1_valid(o1v[0]), .out1_ready(rdy1),
      .phase(ph[0]), .overrun0(ov0[0]), .overrun1(ov1[0])
   );

   demux2 #(.WIDTH(4), .PERIOD(5), .AUTO(1'b1)) dut_a (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .sel(sel),
      .out0_data(o0d[1]), .out0_valid(o0v[1]), .out0_ready(rdy0),
      .out1_data(o1d[1]), .out1_valid(o1v[1]), .out1_ready(rdy1),
      .phase(ph[1]), .overrun0(ov0[1]), .overrun1(ov1[1])
   );

   demux2 #(.WIDTH(4), .PERIOD(1), .AUTO(1'b1)) dut_p1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .sel(sel),
      .out0_data(o0d[2]), .out0_valid(o0v[2]), .out0_ready(rdy0),
      .out1_data(o1d[2]), .out1_valid(o1v[2]), .out1_ready(rdy1),
      .phase(ph[2]), .overrun0(ov0[2]), .overrun1(ov1[2])
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model_phase(input int i);
      return (m_n[i] / PER[i]) % 2;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NI; i++) begin
            m_n[i] = 0;
            for (int c = 0; c < 2; c++) begin
               m_d[i][c] = 4'h0;
               m_v[i][c] = 1'b0;
               m_o[i][c] = 1'b0;
            end
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            int tgt;
            tgt = AUT[i] ? model_phase(i) : int'(sel);
            for (int c = 0; c < 2; c++) begin
               bit r;
               r = (c == 0) ? rdy0 : rdy1;
               if (in_valid && c == tgt) begin
                  if (!m_v[i][c] || r) begin
                     m_d[i][c] = in_data;
                     m_v[i][c] = 1'b1;
                  end else begin
                     m_o[i][c] = 1'b1;
                  end
               end else if (m_v[i][c] && r) begin
                  m_v[i][c] = 1'b0;
               end
            end
            m_n[i] = m_n[i] + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < NI; i++) begin
            check($sformatf("cmp%0d.out0_valid", i), int'(o0v[i]), int'(m_v[i][0]));
            check($sformatf("cmp%0d.out1_valid", i), int'(o1v[i]), int'(m_v[i][1]));
            check($sformatf("cmp%0d.out0_data", i),  int'(o0d[i]), int'(m_d[i][0]));
            check($sformatf("cmp%0d.out1_data", i),  int'(o1d[i]), int'(m_d[i][1]));
            check($sformatf("cmp%0d.overrun0", i),   int'(ov0[i]), int'(m_o[i][0]));
            check($sformatf("cmp%0d.overrun1", i),   int'(ov1[i]), int'(m_o[i][1]));
            check($sformatf("cmp%0d.phase", i),      int'(ph[i]),  model_phase(i));
         end
      end
   end

   function automatic int dut_data(input int i, input int c);
      return (c == 0) ? int'(o0d[i]) : int'(o1d[i]);
   endfunction

   function automatic int dut_valid(input int i, input int c);
      return (c == 0) ? int'(o0v[i]) : int'(o1v[i]);
   endfunction

   initial begin
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 4'hF;
      sel      = 1'b0;
      rdy0     = 1'b0;
      rdy1     = 1'b0;

      // Reset held 3 cycles with a valid word present: everything stays zero.
      repeat (3) begin
         @(negedge clk);
         chk_on = 1'b1;
         for (int i = 0; i < NI; i++) begin
            check("rst.out0_valid", int'(o0v[i]), 0);
            check("rst.out1_valid", int'(o1v[i]), 0);
            check("rst.out0_data",  int'(o0d[i]), 0);
            check("rst.overrun0",   int'(ov0[i]), 0);
            check("rst.phase",      int'(ph[i]),  0);
         end
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst.phase", int'(ph[0]), 0);
      check("post_rst.out0_valid", int'(o0v[0]), 0);

      // Manual steering.
      rdy0 = 1'b1; rdy1 = 1'b1;
      in_valid = 1'b1; sel = 1'b0; in_data = 4'h3;
      @(negedge clk);
      check("man.out0_valid", int'(o0v[0]), 1);
      check("man.out0_data",  int'(o0d[0]), 'h3);
      sel = 1'b1; in_data = 4'hA;
      @(negedge clk);
      check("man.out0_pulse", int'(o0v[0]), 0);
      check("man.out1_valid", int'(o1v[0]), 1);
      check("man.out1_data",  int'(o1d[0]), 'hA);
      check("man.overrun0",   int'(ov0[0]), 0);
      check("man.overrun1",   int'(ov1[0]), 0);
      in_valid = 1'b0;
      @(negedge clk);
      check("man.out1_drained", int'(o1v[0]), 0);

      // Overrun on channel 0.
      rdy0 = 1'b0; sel = 1'b0; in_valid = 1'b1; in_data = 4'h1;
      @(negedge clk);
      check("ovr.first_data", int'(o0d[0]), 'h1);
      in_data = 4'h2;
      @(negedge clk);
      check("ovr.data_held", int'(o0d[0]), 'h1);
      check("ovr.valid_held", int'(o0v[0]), 1);
      check("ovr.overrun0", int'(ov0[0]), 1);
      in_valid = 1'b0; rdy0 = 1'b1;
      @(negedge clk);
      check("ovr.drained", int'(o0v[0]), 0);
      check("ovr.sticky", int'(ov0[0]), 1);

      // Drain and accept on channel 1 in the same cycle.
      rdy1 = 1'b0; sel = 1'b1; in_valid = 1'b1; in_data = 4'h5;
      @(negedge clk);
      check("da.full", int'(o1v[0]), 1);
      check("da.first", int'(o1d[0]), 'h5);
      rdy1 = 1'b1; in_data = 4'h6;
      @(negedge clk);
      check("da.valid", int'(o1v[0]), 1);
      check("da.data", int'(o1d[0]), 'h6);
      check("da.overrun1", int'(ov1[0]), 0);
      in_valid = 1'b0;

      // Auto mode: restart counters, then stream in_data = cycle count.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 18; k++) begin
         in_data = 4'(k);
         @(negedge clk);
         check($sformatf("auto.data%0d", k), dut_data(1, (k / 5) % 2), k % 16);
         check($sformatf("auto.valid%0d", k), dut_valid(1, (k / 5) % 2), 1);
         check($sformatf("auto.phase%0d", k), int'(ph[1]), ((k + 1) / 5) % 2);
         check($sformatf("p1.data%0d", k), dut_data(2, k % 2), k % 16);
         check($sformatf("p1.phase%0d", k), int'(ph[2]), (k + 1) % 2);
      end
      // Now cnt=3 with phase=1: reset mid-stream.
      check("mid.phase_before", int'(ph[1]), 1);
      rst = 1'b1; in_data = 4'hF;
      @(negedge clk);
      check("mid.phase_rst", int'(ph[1]), 0);
      check("mid.out0_valid", int'(o0v[1]), 0);
      check("mid.out1_valid", int'(o1v[1]), 0);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_data = 4'(k + 7);
         @(negedge clk);
         check($sformatf("mid.ch0_data%0d", k), int'(o0d[1]), k + 7);
         check($sformatf("mid.ch1_idle%0d", k), int'(o1v[1]), 0);
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk_on = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
